uart_tx_port: RTL and testbench
===============================

// Module: uart_tx_port
// PURPOSE
//   Memory-mapped serial output stage downstream of the CPU output path.
//   - CPU output-port writes enqueue bytes into a small FIFO.
//   - A serializer drains the FIFO onto uart_tx as 8N1 frames.
//   - Status outputs let programs poll full/busy instead of stalling the CPU.
//   - Lives inside computer, beside output_port_1, driven by the same store-to-port decode.
// PARAMETERS
//   CLKS_PER_BIT  434  clk cycles per serial bit (115200 baud @ 50 MHz); must be >= 2
//   FIFO_DEPTH    4    byte entries in the FIFO; power of two, >= 2
// PORTS
//   clk           in   1           system clock, all logic on posedge
//   reset         in   1           synchronous, active-high
//   wr_en         in   1           enqueue wr_data this cycle (one-cycle strobe from port decode)
//   wr_data       in   DATA_WIDTH  byte to transmit
//   clr_overflow  in   1           clears the sticky overflow flag
//   uart_tx       out  1           serial line, idle high
//   fifo_full     out  1           FIFO holds FIFO_DEPTH entries
//   fifo_empty    out  1           FIFO holds 0 entries
//   busy          out  1           serializer not IDLE, or FIFO not empty
//   overflow      out  1           sticky: a write was dropped
//   tx_done       out  1           one-cycle pulse at the end of each stop bit
// BEHAVIOUR
//   Reset values: uart_tx=1, fifo_full=0, fifo_empty=1, busy=0, overflow=0, tx_done=0.
//     FIFO pointers and count are 0; serializer is in IDLE.
//   FIFO: circular buffer with rd/wr pointers that wrap modulo FIFO_DEPTH.
//     - wr_en while not full: write at wr_ptr, then wr_ptr++.
//     - wr_en while full with no pop that cycle: data dropped, overflow<=1.
//     - wr_en while full with a pop that cycle: write accepted, count unchanged.
//     - Pop and write in the same cycle: count unchanged, both pointers advance.
//     - overflow clears only on clr_overflow or reset; a set in the same cycle as clr wins.
//   Serializer states (typedef uart_tx_state_t):
//     IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//     - IDLE: if FIFO is not empty, pop the head into the shift register and enter START.
//       Load happens on the edge after the write, so uart_tx goes low 1 cycle after wr_data is captured.
//     - START: uart_tx=0 for CLKS_PER_BIT cycles.
//     - DATA: 8 bits LSB first, CLKS_PER_BIT cycles each; bit counter runs 0..7.
//     - STOP: uart_tx=1 for CLKS_PER_BIT cycles; tx_done pulses on its last cycle.
//       If the FIFO is not empty, STOP goes directly to START, popping the next byte on that edge.
//       This gives back-to-back frames with no idle gap.
//   Baud counter counts 0..CLKS_PER_BIT-1 and resets on every state change.
//   Frame length: 10*CLKS_PER_BIT cycles (11* with parity).
//   Capacity: up to FIFO_DEPTH+1 bytes in flight (FIFO plus shift register).
//   Reset mid-frame: the next edge forces uart_tx=1 and IDLE and empties the FIFO.
//     No partial frame completes.
//   uart_tx is driven from a register; no combinational glitches.
// CONFIGURATION
//   UART_TX_PARITY_EN
//     - Defined: PARITY state after DATA, driving even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
//     - Undefined: PARITY state and its logic are absent; DATA goes directly to STOP.
// STRUCTURE
//   arch_defs_pkg: uart_tx_state_t enum (IDLE, START, DATA, PARITY, STOP).
//     Also holds the UART_DEFAULT_CLKS_PER_BIT constant; DATA_WIDTH already lives there.
//   Sub-module byte_fifo (DEPTH, WIDTH params): storage, pointers, full/empty, registered count.
//   uart_tx_port holds the FSM, baud counter, shift register and the overflow flag.
// TESTING  (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4)
//   1. Reset -> uart_tx=1, fifo_empty=1, busy=0, overflow=0, held for 20 cycles.
//   2. Single byte: wr 8'h55 -> start bit 1 cycle later.
//      Line sequence 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles.
//      tx_done pulse at cycle 40 of the frame, then busy=0.
//   3. Back-to-back: wr 8'hA5 then 8'h0F on consecutive cycles.
//      Two frames with no idle gap; sampled bytes A5, 0F; exactly 2 tx_done pulses.
//   4. Overflow: 6 consecutive writes 8'h01..8'h06.
//      First 5 accepted, 6th dropped, overflow=1, fifo_full=1.
//      Line carries 01..05; clr_overflow -> overflow=0.
//   5. Full write+pop: with FIFO full, wr on the cycle STOP pops the next byte.
//      Write accepted, overflow stays 0, fifo_full stays 1.
//   6. Reset mid-frame: pulse reset during DATA bit 3 -> uart_tx=1 next cycle.
//      fifo_empty=1 and no tx_done pulse.
//   7. With UART_TX_PARITY_EN: wr 8'h07 -> parity bit 1; frame is 44 cycles.

Source files
------------

// File: rtl/arch_defs_pkg.sv
// arch_defs_pkg: shared architecture constants and the UART transmitter state type.
package arch_defs_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int UART_DEFAULT_CLKS_PER_BIT = 434;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: circular buffer with wrapping pointers, registered count, full/empty flags.
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] count_q;
  logic do_push, do_pop;
  assign do_pop = pop_i && !empty_o;
  // a full FIFO still accepts a write when the head leaves in the same cycle
  assign do_push = push_i && (!full_o || do_pop);
  assign full_o = count_q == (AW+1)'(DEPTH);
  assign empty_o = count_q == '0;
  assign dout_o = mem_q[rd_ptr_q];
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/uart_tx_port.sv
// uart_tx_port: FIFO-buffered 8N1 serial transmitter with pollable status flags.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_port
  import arch_defs_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  clr_overflow,
  output logic                  uart_tx,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  busy,
  output logic                  overflow,
  output logic                  tx_done
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  uart_tx_state_t state_q;
  logic [BW-1:0] baud_q;
  logic [2:0] bit_q;
  logic [DATA_WIDTH-1:0] shift_q, head;
  logic tx_q, done_q, ovf_q, pop, bit_end;
`ifdef UART_TX_PARITY_EN
  logic par_q;
`endif
  byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_WIDTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push_i(wr_en),
    .pop_i(pop),
    .din_i(wr_data),
    .dout_o(head),
    .full_o(fifo_full),
    .empty_o(fifo_empty)
  );
  assign bit_end = baud_q == BW'(CLKS_PER_BIT-1);
  // STOP hands straight over to the next frame so queued bytes leave with no idle gap
  assign pop = !fifo_empty && (state_q == IDLE || (state_q == STOP && bit_end));
  assign uart_tx = tx_q;
  assign tx_done = done_q;
  assign overflow = ovf_q;
  assign busy = state_q != IDLE || !fifo_empty;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      tx_q <= 1'b1;
      done_q <= 1'b0;
      ovf_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      baud_q <= (state_q == IDLE || bit_end) ? '0 : baud_q + 1'b1;
      done_q <= state_q == STOP && baud_q == BW'(CLKS_PER_BIT-2);
      ovf_q <= (wr_en && fifo_full && !pop) || (ovf_q && !clr_overflow);
      if (pop) begin
        shift_q <= head;
        state_q <= START;
        tx_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
        par_q <= ^head;
`endif
      end else if (bit_end) begin
        case (state_q)
          START: begin
            state_q <= DATA;
            bit_q <= '0;
            tx_q <= shift_q[0];
          end
          DATA: begin
            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= PARITY;
              tx_q <= par_q;
`else
              state_q <= STOP;
              tx_q <= 1'b1;
`endif
            end else begin
              bit_q <= bit_q + 1'b1;
              shift_q <= shift_q >> 1;
              tx_q <= shift_q[1];
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            state_q <= STOP;
            tx_q <= 1'b1;
          end
`endif
          default: begin
            state_q <= IDLE;
            tx_q <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_port.sv
// tb_uart_tx_port: table-driven frame checks plus directed overflow/back-to-back/reset sequences.
module tb_uart_tx_port;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = CPB * NB;
  logic clk, reset, wr_en, clr_overflow;
  logic [7:0] wr_data;
  logic uart_tx, fifo_full, fifo_empty, busy, overflow, tx_done;
  int checks = 0, failures = 0;
  int cyc = 0, mcnt = 0, done_cnt = 0, start_cyc = 0, gap = 0, stop_err = 0;
  logic [7:0] mbyte;
  logic [7:0] rx_q[$];
  typedef struct {
    logic [7:0] d;
    logic [9:0] line;
    logic par;
  } vec_t;
  vec_t vecs[6];

  uart_tx_port #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .clr_overflow(clr_overflow),
    .uart_tx(uart_tx),
    .fifo_full(fifo_full),
    .fifo_empty(fifo_empty),
    .busy(busy),
    .overflow(overflow),
    .tx_done(tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // independent receiver: samples mid-bit on the falling edge
  always @(negedge clk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (reset) mcnt <= 0;
    else if (mcnt == 0) begin
      if (!uart_tx) begin
        mcnt <= 1;
        gap <= cyc - start_cyc;
        start_cyc <= cyc;
      end
    end else begin
      mcnt <= mcnt + 1;
      for (int i = 0; i < 8; i++) if (mcnt == CPB * (i + 1) + CPB / 2 - 1) mbyte[i] <= uart_tx;
      if (mcnt == CPB * (NB - 1) + CPB / 2 - 1) begin
        rx_q.push_back(mbyte);
        if (!uart_tx) stop_err <= stop_err + 1;
        mcnt <= 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, r0, k;
    logic e;
    vecs[0] = '{8'h55, 10'h2AA, 1'b0};
    vecs[1] = '{8'hA5, 10'h34A, 1'b0};
    vecs[2] = '{8'h0F, 10'h21E, 1'b0};
    vecs[3] = '{8'hFF, 10'h3FE, 1'b0};
    vecs[4] = '{8'h00, 10'h200, 1'b0};
    vecs[5] = '{8'h07, 10'h20E, 1'b1};
    reset = 1'b1;
    wr_en = 1'b0;
    wr_data = '0;
    clr_overflow = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("rst_tx", uart_tx, 1);
      chk("rst_empty", fifo_empty, 1);
      chk("rst_busy", busy, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_full", fifo_full, 0);
      chk("rst_done", tx_done, 0);
    end
    reset = 1'b0;
    step();
    // single frames from the table
    for (int v = 0; v < 6; v++) begin
      write(vecs[v].d);
      chk("busy_after_wr", busy, 1);
      for (int c = 1; c <= FL; c++) begin
        step();
        k = (c - 1) / CPB;
        e = k < 9 ? vecs[v].line[k] : (k == NB - 1 ? 1'b1 : vecs[v].par);
        chk($sformatf("line_v%0d_c%0d", v, c), uart_tx, e);
        chk($sformatf("done_v%0d_c%0d", v, c), tx_done, c == FL);
      end
      step();
      chk("busy_idle", busy, 0);
      chk("empty_idle", fifo_empty, 1);
      chk("rx_count", rx_q.size(), 1);
      if (rx_q.size() > 0) chk($sformatf("rx_v%0d", v), rx_q.pop_front(), vecs[v].d);
    end
    // back-to-back frames
    d0 = done_cnt;
    write(8'hA5);
    write(8'h0F);
    for (int i = 0; i < 3 * FL && rx_q.size() < 2; i++) step();
    chk("b2b_count", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      chk("b2b_byte0", rx_q.pop_front(), 8'hA5);
      chk("b2b_byte1", rx_q.pop_front(), 8'h0F);
    end
    chk("b2b_gap", gap, FL);
    for (int i = 0; i < FL && busy; i++) step();
    chk("b2b_busy", busy, 0);
    chk("b2b_dones", done_cnt - d0, 2);
    // overflow, clear, then write into a full FIFO on the popping cycle
    for (int i = 1; i <= 6; i++) write(8'(i));
    chk("ovf_set", overflow, 1);
    chk("ovf_full", fifo_full, 1);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    chk("ovf_clr", overflow, 0);
    for (int i = 0; i < 2 * FL && !tx_done; i++) step();
    chk("wait_pop", tx_done, 1);
    write(8'h06);
    chk("wrpop_ovf", overflow, 0);
    chk("wrpop_full", fifo_full, 1);
    for (int i = 0; i < 7 * FL && rx_q.size() < 6; i++) step();
    chk("ovf_rx_count", rx_q.size(), 6);
    for (int i = 1; i <= 6 && rx_q.size() > 0; i++) chk($sformatf("ovf_rx%0d", i), rx_q.pop_front(), i);
    for (int i = 0; i < FL && busy; i++) step();
    chk("ovf_busy", busy, 0);
    chk("stop_bits", stop_err, 0);
    // reset during data bit 3
    d0 = done_cnt;
    r0 = rx_q.size();
    write(8'hC3);
    repeat (18) step();
    chk("mid_bit3", uart_tx, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst_tx", uart_tx, 1);
    chk("mrst_empty", fifo_empty, 1);
    chk("mrst_busy", busy, 0);
    k = 0;
    for (int i = 0; i < 2 * FL; i++) begin
      step();
      if (!uart_tx) k++;
    end
    chk("mrst_line_idle", k, 0);
    chk("mrst_no_done", done_cnt - d0, 0);
    chk("mrst_no_rx", rx_q.size(), r0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
